// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO.
// Status flags (full/empty/idle) decode the registered FIFO count and FSM state.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_idle,
  output logic       o_ovf,
  output logic       o_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [7:0]    shift;
  logic [BW-1:0] baud;
  logic [2:0]    idx;
  logic          push, pop, baud_done;

  assign o_full    = (count == DEPTH_C);
  assign o_empty   = (count == '0);
  assign o_idle    = (state == IDLE) && o_empty;
  assign push      = i_wr_en && !o_full;
  assign baud_done = (baud == BAUD_LAST);
  // STOP pops on its final cycle so the next start bit follows with no gap
  assign pop       = !o_empty && ((state == IDLE) || (state == STOP && baud_done));

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_ovf  <= 1'b0;
    end else begin
      // a write against a full FIFO is dropped even if a pop frees a slot
      o_ovf <= i_wr_en && o_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_txd <= 1'b1;
      shift <= '0;
      baud  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          idx  <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            o_txd <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud  <= '0;
            idx   <= '0;
            state <= DATA;
            o_txd <= shift[0];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
              o_txd <= 1'b1;
            end else begin
              shift <= {1'b0, shift[7:1]};
              o_txd <= shift[1];
              idx   <= idx + 3'd1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              o_txd <= 1'b0;
            end else begin
              state <= IDLE;
              o_txd <= 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          o_txd <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks/bit, depth 4.
// Inputs are driven and outputs sampled on the falling edge; txd is logged every cycle.
module tb_uart_tx_fifo;
  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, idle, ovf, txd;
  int         n_chk = 0, n_fail = 0;
  logic       cap[$];
  bit         cap_en = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_idle(idle), .o_ovf(ovf), .o_txd(txd)
  );

  always #5 clk = ~clk;

  // cap[j] holds txd just after the j-th rising edge since cap_start
  always @(posedge clk) begin
    #1;
    if (cap_en) cap.push_back(txd);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish within 1ms");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit0 = start, bits1..8 = data LSB first, bit9 = stop
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic cap_start();
    cap_en = 1'b0;
    cap.delete();
    cap_en = 1'b1;
  endtask

  // mid-bit samples of the frame whose start bit first appears at cap[s]
  function automatic logic [9:0] grab(input int s);
    logic [9:0] r;
    for (int b = 0; b < 10; b++) begin
      int i = s + 4*b + 2;
      r[b] = (i < cap.size()) ? cap[i] : 1'bx;
    end
    return r;
  endfunction

  function automatic bit low_from(input int s);
    for (int i = s; i < cap.size(); i++)
      if (cap[i] !== 1'b1) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [79:0] act80, exp80;
    logic [9:0]  fr0, fr1;
    logic [7:0]  ovf_bytes[5];
    logic [7:0]  bnd_bytes[6];
    bit bad;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    // reset values and quiet idle
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_txd", txd, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_idle", idle, 1);
    check("rst_ovf", ovf, 0);
    bad = 1'b0;
    repeat (100) begin
      tick(1);
      if ({txd, empty, full, idle, ovf} !== 5'b11010) bad = 1'b1;
    end
    check("idle_hold_100", bad, 0);

    // single frames from the table
    foreach (vecs[v]) begin
      cap_start();
      wr(vecs[v].data);                     // edge k
      check($sformatf("v%0d_txd_k", v), txd, 1);
      check($sformatf("v%0d_empty_k", v), empty, 0);
      tick(1);                              // edge k+1
      check($sformatf("v%0d_txd_k1", v), txd, 0);
      check($sformatf("v%0d_empty_k1", v), empty, 1);
      tick(39);
      check($sformatf("v%0d_idle_k40", v), idle, 0);
      tick(1);
      check($sformatf("v%0d_idle_k41", v), idle, 1);
      check($sformatf("v%0d_frame", v), grab(1), vecs[v].frame);
    end

    // back-to-back 0x00, 0xFF: 80 contiguous cycles, no gap
    cap_start();
    wr(8'h00);
    wr(8'hFF);
    tick(80);
    fr0 = 10'b1000000000;
    fr1 = 10'b1111111110;
    for (int c = 0; c < 80; c++) begin
      exp80[c] = (c < 40) ? fr0[c/4] : fr1[(c-40)/4];
      act80[c] = (1 + c < cap.size()) ? cap[1 + c] : 1'bx;
    end
    check("b2b_80cyc", act80, exp80);
    check("b2b_idle", idle, 1);

    // overflow: 0x06 dropped
    cap_start();
    for (int b = 1; b <= 5; b++) wr(8'(b));
    check("ovf_full", full, 1);
    check("ovf_pre", ovf, 0);
    wr(8'h06);
    check("ovf_pulse", ovf, 1);
    tick(1);
    check("ovf_clear", ovf, 0);
    tick(200);
    ovf_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    foreach (ovf_bytes[i])
      check($sformatf("ovf_frame%0d", i), grab(1 + 40*i), {1'b1, ovf_bytes[i], 1'b0});
    check("ovf_no_6th", low_from(202), 0);
    check("ovf_idle", idle, 1);

    // reset during DATA bit 3 of 0x00 with two bytes queued
    wr(8'h00);
    wr(8'hAA);
    wr(8'h55);
    tick(16);
    check("mid_bit3", txd, 0);
    check("mid_queued", empty, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd", txd, 1);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_idle", idle, 1);
    tick(2);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      tick(1);
      if (txd !== 1'b1 || idle !== 1'b1) bad = 1'b1;
    end
    check("mid_no_frames", bad, 0);

    // full FIFO, write lands on the STOP edge that pops
    cap_start();
    wr(8'hC3);
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    tick(36);                               // after edge k+40
    check("bnd_full", full, 1);
    check("bnd_stop", txd, 1);
    wr(8'h77);                              // edge k+41
    check("bnd_ovf", ovf, 1);
    check("bnd_full_after", full, 0);
    check("bnd_empty_after", empty, 0);
    check("bnd_next_start", txd, 0);
    wr(8'h99);                              // count was DEPTH-1, now full again
    check("bnd_refill_full", full, 1);
    check("bnd_refill_ovf", ovf, 0);
    tick(205);
    bnd_bytes = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
    foreach (bnd_bytes[i])
      check($sformatf("bnd_frame%0d", i), grab(1 + 40*i), {1'b1, bnd_bytes[i], 1'b0});
    check("bnd_no_extra", low_from(242), 0);
    check("bnd_idle", idle, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serial UART transmitter that sits directly downstream of the SOC's memory-mapped UART data register and drives the `TXD` pin. The CPU-side write port pushes bytes into a small FIFO. A shifter drains the FIFO and emits standard 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed integer clocks-per-bit rate. Status outputs feed the SOC's UART status register so firmware can poll before writing.

## Interface
- `CLKS_PER_BIT`, default 100: clock cycles per serial bit (100 MHz / 1 Mbaud). Must be ≥ 2.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_wr_en`  in  1  write strobe; sampled on the rising edge.
- `i_wr_data`  in  8  byte to enqueue.
- `o_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_idle`  out  1  FIFO empty and shifter in IDLE.
- `o_ovf`  out  1  one-cycle pulse when a write is dropped.
- `o_txd`  out  1  serial output; idle level high.

## Operation
- **FIFO.**
  - Write is accepted when `i_wr_en && !o_full` at a rising edge.
  - If `o_full` is set in that cycle, the write is dropped and `o_ovf` pulses high for the following cycle. This holds even if a pop occurs on the same edge.
  - Pop and accepted write on the same edge: the count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. The count register is `$clog2(FIFO_DEPTH)+1` bits wide.
- **Shifter FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `o_txd`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: `o_txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `o_txd`=`shift[0]`. After `CLKS_PER_BIT` cycles, shift right and increment the index. After the 8th bit, go to STOP.
  - STOP: `o_txd`=1 for `CLKS_PER_BIT` cycles. On the final cycle:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Counters.**
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1.
  - Bit index: 3 bits.
- **Output decode.** `o_txd` comes from a register, not combinational decode, so there are no glitches.
- **Reset (async assert, sync release).**
  - State=IDLE, FIFO flushed (pointers and count zero).
  - `o_txd`=1, `o_full`=0, `o_empty`=1, `o_idle`=1, `o_ovf`=0.
  - Reset mid-frame: `o_txd` returns high immediately, and the partial frame is abandoned.

## Timing
- Write accepted at edge k into an empty FIFO, shifter IDLE:
  - `o_empty` falls after edge k.
  - Pop at edge k+1; `o_txd` falls after edge k+1.
  - `o_empty` rises again after edge k+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from start-bit falling edge to end of stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Status flags (`o_full`, `o_empty`, `o_idle`) update on the edge following the causing event.
- `o_idle` is high only in IDLE with an empty FIFO. It is low throughout START/DATA/STOP.

## Test plan
- **Reset values.** Hold `i_rst_n`=0, then release.
  - Expect `o_txd`=1, `o_empty`=1, `o_full`=0, `o_idle`=1, `o_ovf`=0.
  - Expect no change over 100 idle cycles.
- **Single byte** (`CLKS_PER_BIT`=4). Write 0xA5 at edge k.
  - `o_txd` falls after edge k+1.
  - Sampled every 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - `o_idle`=1 at cycle k+1+40.
- **Back-to-back.** Write 0x00 then 0xFF on consecutive edges.
  - 80 contiguous cycles: start, eight 0s, stop, start, eight 1s, stop.
  - No extra high cycle between the frames.
- **Overflow** (`FIFO_DEPTH`=4). Write 0x01..0x06 on six consecutive edges.
  - 0x01 pops immediately; 0x02..0x05 fill the FIFO; `o_full`=1.
  - 0x06 is dropped, and `o_ovf` pulses for exactly 1 cycle.
  - Serial output carries 0x01..0x05 only.
- **Reset mid-frame.** Assert `i_rst_n`=0 during the DATA bit 3 of 0x00 with 2 bytes queued.
  - `o_txd`=1 immediately (before the next clock edge).
  - `o_empty`=1.
  - After release: no further frames.
- **Full-boundary write with simultaneous pop.** FIFO full and STOP ending on the same edge as a write.
  - Write dropped and `o_ovf` pulses; count becomes `FIFO_DEPTH`-1.
